// File: rtl/p_id_ex.sv
// ----------------------------------------------------------------------------
// p_id_ex - ID/EX pipeline register for the 5-stage MIPS32 pipeline.
//
// Captures the decoded instruction (register-file read data, immediate,
// control, register addresses) at the end of ID and presents it to EX one
// cycle later. Detects a load in EX whose destination is read by the
// instruction in ID, requests an upstream stall and inserts a bubble.
// Branch flush and an external hold are also handled here, and the number of
// load-use bubbles is counted (saturating at 0xFFFF).
//
// Ports
//   i_sys_clock, i_sys_reset      clock, synchronous active-high reset
//   i_p_id_ex_valid               ID holds a real instruction
//   i_p_id_ex_pc_plus4            PC+4 of the ID instruction
//   i_p_id_ex_rs/rt/rd_addr       instruction register fields
//   i_p_id_ex_uses_rs/uses_rt     instruction really reads rs / rt
//   i_p_id_ex_rs/rt_data          register-file read data
//   i_p_id_ex_imm                 extended immediate
//   i_p_id_ex_ctrl                [0] regwr [1] memrd [2] memwr [3] memtoreg
//                                 [4] alusrc [5] regdst [6] link [9:7] aluop
//   i_p_id_ex_flush               taken branch/jump in EX, kill ID instruction
//   i_p_id_ex_hold                global freeze
//   o_p_id_ex_*                   registered EX-stage copies
//   o_p_id_ex_wr_addr             resolved destination register
//   o_p_id_ex_stall               load-use stall request (combinational)
//   o_p_id_ex_bubble_cnt          load-use bubbles inserted, saturating
// ----------------------------------------------------------------------------
module p_id_ex (
   input  logic        i_sys_clock,
   input  logic        i_sys_reset,
   input  logic        i_p_id_ex_valid,
   input  logic [31:0] i_p_id_ex_pc_plus4,
   input  logic [4:0]  i_p_id_ex_rs_addr,
   input  logic [4:0]  i_p_id_ex_rt_addr,
   input  logic [4:0]  i_p_id_ex_rd_addr,
   input  logic        i_p_id_ex_uses_rs,
   input  logic        i_p_id_ex_uses_rt,
   input  logic [31:0] i_p_id_ex_rs_data,
   input  logic [31:0] i_p_id_ex_rt_data,
   input  logic [31:0] i_p_id_ex_imm,
   input  logic [9:0]  i_p_id_ex_ctrl,
   input  logic        i_p_id_ex_flush,
   input  logic        i_p_id_ex_hold,
   output logic        o_p_id_ex_valid,
   output logic [31:0] o_p_id_ex_pc_plus4,
   output logic [31:0] o_p_id_ex_rs_data,
   output logic [31:0] o_p_id_ex_rt_data,
   output logic [31:0] o_p_id_ex_imm,
   output logic [4:0]  o_p_id_ex_rs_addr,
   output logic [4:0]  o_p_id_ex_rt_addr,
   output logic [4:0]  o_p_id_ex_wr_addr,
   output logic [9:0]  o_p_id_ex_ctrl,
   output logic        o_p_id_ex_stall,
   output logic [15:0] o_p_id_ex_bubble_cnt
);

   localparam logic [4:0]  LinkReg = 5'd31;
   localparam logic [15:0] CntMax  = 16'hFFFF;

   localparam int unsigned CtrlMemrd  = 1;
   localparam int unsigned CtrlRegdst = 5;
   localparam int unsigned CtrlLink   = 6;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc_plus4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  wr_addr;
      logic [9:0]  ctrl;
   } stage_t;

   stage_t      stage_q, stage_d, capture;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   logic [4:0]  dest_addr;
   logic        rs_match, rt_match, hazard;

   // Destination register: link wins over regdst, default is rt.
   always_comb begin
      dest_addr = i_p_id_ex_rt_addr;
      if (i_p_id_ex_ctrl[CtrlLink]) begin
         dest_addr = LinkReg;
      end else if (i_p_id_ex_ctrl[CtrlRegdst]) begin
         dest_addr = i_p_id_ex_rd_addr;
      end
   end

   // Contents to load on a normal capture; an invalid ID slot becomes a bubble.
   always_comb begin
      capture = '0;
      if (i_p_id_ex_valid) begin
         capture.valid    = 1'b1;
         capture.pc_plus4 = i_p_id_ex_pc_plus4;
         capture.rs_data  = i_p_id_ex_rs_data;
         capture.rt_data  = i_p_id_ex_rt_data;
         capture.imm      = i_p_id_ex_imm;
         capture.rs_addr  = i_p_id_ex_rs_addr;
         capture.rt_addr  = i_p_id_ex_rt_addr;
         capture.wr_addr  = dest_addr;
         capture.ctrl     = i_p_id_ex_ctrl;
      end
   end

   // Load-use: the load in EX cannot forward until MEM, so the ID consumer
   // must wait one cycle. Register 0 is never a real dependency.
   always_comb begin
      rs_match = i_p_id_ex_uses_rs && (i_p_id_ex_rs_addr == stage_q.wr_addr);
      rt_match = i_p_id_ex_uses_rt && (i_p_id_ex_rt_addr == stage_q.wr_addr);
      hazard   = stage_q.valid && stage_q.ctrl[CtrlMemrd] && (stage_q.wr_addr != 5'd0) &&
                 i_p_id_ex_valid && (rs_match || rt_match);
   end

   // Flush and hold both override the hazard: a flushed consumer needs no
   // stall, and under hold nothing moves so the hazard is re-evaluated later.
   assign o_p_id_ex_stall = hazard && !i_p_id_ex_flush && !i_p_id_ex_hold;

   always_comb begin
      stage_d      = stage_q;
      bubble_cnt_d = bubble_cnt_q;
      if (i_p_id_ex_flush) begin
         stage_d = '0;
      end else if (i_p_id_ex_hold) begin
         stage_d = stage_q;
      end else if (hazard) begin
         stage_d = '0;
         if (bubble_cnt_q != CntMax) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
         end
      end else begin
         stage_d = capture;
      end
   end

   always_ff @(posedge i_sys_clock) begin
      if (i_sys_reset) begin
         stage_q      <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stage_q      <= stage_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign o_p_id_ex_valid      = stage_q.valid;
   assign o_p_id_ex_pc_plus4   = stage_q.pc_plus4;
   assign o_p_id_ex_rs_data    = stage_q.rs_data;
   assign o_p_id_ex_rt_data    = stage_q.rt_data;
   assign o_p_id_ex_imm        = stage_q.imm;
   assign o_p_id_ex_rs_addr    = stage_q.rs_addr;
   assign o_p_id_ex_rt_addr    = stage_q.rt_addr;
   assign o_p_id_ex_wr_addr    = stage_q.wr_addr;
   assign o_p_id_ex_ctrl       = stage_q.ctrl;
   assign o_p_id_ex_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_p_id_ex.sv
// ----------------------------------------------------------------------------
// tb_p_id_ex - self-checking bench for p_id_ex. Directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model of
// the ID/EX stage contents and the bubble count.
// ----------------------------------------------------------------------------
module tb_p_id_ex;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic        in_uses_rs, in_uses_rt;
   logic [31:0] in_rsd, in_rtd, in_imm;
   logic [9:0]  in_ctrl;
   logic        in_flush, in_hold;

   logic        o_valid;
   logic [31:0] o_pc, o_rsd, o_rtd, o_imm;
   logic [4:0]  o_rs, o_rt, o_wr;
   logic [9:0]  o_ctrl;
   logic        o_stall;
   logic [15:0] o_cnt;

   localparam logic [9:0] CtrlAdd = 10'h021;  // regwr | regdst
   localparam logic [9:0] CtrlLw  = 10'h01B;  // regwr | memrd | memtoreg | alusrc
   localparam logic [9:0] CtrlJal = 10'h041;  // regwr | link

   p_id_ex dut (
      .i_sys_clock          (clk),
      .i_sys_reset          (rst),
      .i_p_id_ex_valid      (in_valid),
      .i_p_id_ex_pc_plus4   (in_pc),
      .i_p_id_ex_rs_addr    (in_rs),
      .i_p_id_ex_rt_addr    (in_rt),
      .i_p_id_ex_rd_addr    (in_rd),
      .i_p_id_ex_uses_rs    (in_uses_rs),
      .i_p_id_ex_uses_rt    (in_uses_rt),
      .i_p_id_ex_rs_data    (in_rsd),
      .i_p_id_ex_rt_data    (in_rtd),
      .i_p_id_ex_imm        (in_imm),
      .i_p_id_ex_ctrl       (in_ctrl),
      .i_p_id_ex_flush      (in_flush),
      .i_p_id_ex_hold       (in_hold),
      .o_p_id_ex_valid      (o_valid),
      .o_p_id_ex_pc_plus4   (o_pc),
      .o_p_id_ex_rs_data    (o_rsd),
      .o_p_id_ex_rt_data    (o_rtd),
      .o_p_id_ex_imm        (o_imm),
      .o_p_id_ex_rs_addr    (o_rs),
      .o_p_id_ex_rt_addr    (o_rt),
      .o_p_id_ex_wr_addr    (o_wr),
      .o_p_id_ex_ctrl       (o_ctrl),
      .o_p_id_ex_stall      (o_stall),
      .o_p_id_ex_bubble_cnt (o_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: what instruction sits in EX, and how many bubbles so far.
   typedef struct {
      bit          valid;
      logic [31:0] pc, rsd, rtd, imm;
      logic [4:0]  rs, rt, wr;
      logic [9:0]  ctrl;
   } ex_slot_t;

   ex_slot_t    m;
   int unsigned m_cnt;

   function automatic ex_slot_t empty_slot();
      ex_slot_t s;
      s.valid = 0; s.pc = 0; s.rsd = 0; s.rtd = 0; s.imm = 0;
      s.rs = 0; s.rt = 0; s.wr = 0; s.ctrl = 0;
      return s;
   endfunction

   // EX holds a load writing a nonzero register that ID really reads.
   function automatic bit m_load_use();
      bit is_load = m.valid && (m.ctrl[1] == 1'b1) && (m.wr != 5'd0);
      bit reads   = (in_uses_rs && in_rs == m.wr) || (in_uses_rt && in_rt == m.wr);
      return is_load && in_valid && reads;
   endfunction

   function automatic bit m_stall();
      return m_load_use() && !in_flush && !in_hold;
   endfunction

   task automatic model_step();
      ex_slot_t nxt;
      if (rst) begin
         m = empty_slot();
         m_cnt = 0;
      end else if (in_flush) begin
         m = empty_slot();
      end else if (in_hold) begin
         // nothing moves
      end else if (m_load_use()) begin
         m = empty_slot();
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (!in_valid) begin
         m = empty_slot();
      end else begin
         nxt.valid = 1;
         nxt.pc = in_pc; nxt.rsd = in_rsd; nxt.rtd = in_rtd; nxt.imm = in_imm;
         nxt.rs = in_rs; nxt.rt = in_rt; nxt.ctrl = in_ctrl;
         if (in_ctrl[6])      nxt.wr = 5'd31;
         else if (in_ctrl[5]) nxt.wr = in_rd;
         else                 nxt.wr = in_rt;
         m = nxt;
      end
   endtask

   task automatic compare_outputs();
      check("valid", 32'(o_valid), 32'(m.valid));
      check("pc_plus4", o_pc, m.pc);
      check("rs_data", o_rsd, m.rsd);
      check("rt_data", o_rtd, m.rtd);
      check("imm", o_imm, m.imm);
      check("rs_addr", 32'(o_rs), 32'(m.rs));
      check("rt_addr", 32'(o_rt), 32'(m.rt));
      check("wr_addr", 32'(o_wr), 32'(m.wr));
      check("ctrl", 32'(o_ctrl), 32'(m.ctrl));
      check("bubble_cnt", 32'(o_cnt), m_cnt);
   endtask

   // One cycle: check the combinational stall, clock, then check registers.
   task automatic tick();
      #1;
      check("stall", 32'(o_stall), 32'(m_stall()));
      @(posedge clk);
      model_step();
      #1;
      compare_outputs();
   endtask

   task automatic idle();
      rst = 0; in_valid = 0; in_pc = 0; in_rs = 0; in_rt = 0; in_rd = 0;
      in_uses_rs = 0; in_uses_rt = 0; in_rsd = 0; in_rtd = 0; in_imm = 0;
      in_ctrl = 0; in_flush = 0; in_hold = 0;
   endtask

   task automatic instr(input logic [9:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input bit urs, input bit urt);
      idle();
      in_valid = 1; in_ctrl = ctrl; in_rs = rs; in_rt = rt; in_rd = rd;
      in_uses_rs = urs; in_uses_rt = urt;
      in_pc = $urandom; in_rsd = $urandom; in_rtd = $urandom; in_imm = $urandom;
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1:       return 5'd8;
         2:       return 5'd9;
         default: return 5'($urandom);
      endcase
   endfunction

   task automatic rand_inputs();
      instr(10'($urandom), pick_reg(), pick_reg(), pick_reg(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1);
      in_ctrl[1] = $urandom_range(0, 1);
      in_valid   = $urandom_range(0, 9) != 0;
      in_flush   = $urandom_range(0, 9) == 0;
      in_hold    = $urandom_range(0, 7) == 0;
      rst        = $urandom_range(0, 49) == 0;
   endtask

   initial begin
      m = empty_slot();
      m_cnt = 0;

      // Reset for two cycles with busy inputs.
      instr(CtrlAdd, 5'd8, 5'd9, 5'd10, 1, 1);
      rst = 1;
      @(posedge clk);
      model_step();
      #1;
      tick();
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_cnt", 32'(o_cnt), 32'd0);

      // Pass-through add $10, $8, $9.
      instr(CtrlAdd, 5'd8, 5'd9, 5'd10, 1, 1);
      in_rsd = 32'h11; in_rtd = 32'h22;
      tick();
      check("pt_valid", 32'(o_valid), 32'd1);
      check("pt_wr", 32'(o_wr), 32'd10);
      check("pt_rsd", o_rsd, 32'h11);
      check("pt_rtd", o_rtd, 32'h22);
      check("pt_ctrl", 32'(o_ctrl), 32'(CtrlAdd));

      // Load-use: lw $8 then add reading $8.
      instr(CtrlLw, 5'd9, 5'd8, 5'd0, 1, 0);
      tick();
      instr(CtrlAdd, 5'd8, 5'd9, 5'd10, 1, 1);
      #1;
      check("lu_stall", 32'(o_stall), 32'd1);
      tick();
      check("lu_bubble", 32'(o_valid), 32'd0);
      check("lu_bubble_ctrl", 32'(o_ctrl), 32'd0);
      check("lu_cnt", 32'(o_cnt), 32'd1);
      check("lu_stall_gone", 32'(o_stall), 32'd0);
      tick();
      check("lu_capture", 32'(o_valid), 32'd1);
      check("lu_capture_wr", 32'(o_wr), 32'd10);

      // No hazard through $0, nor when rs is not really read.
      instr(CtrlLw, 5'd9, 5'd0, 5'd0, 1, 0);
      tick();
      instr(CtrlAdd, 5'd0, 5'd9, 5'd10, 1, 1);
      #1;
      check("nh_zero", 32'(o_stall), 32'd0);
      tick();
      instr(CtrlLw, 5'd9, 5'd8, 5'd0, 1, 0);
      tick();
      instr(CtrlAdd, 5'd8, 5'd9, 5'd10, 0, 1);
      #1;
      check("nh_unused", 32'(o_stall), 32'd0);
      tick();

      // Flush beats hazard.
      instr(CtrlLw, 5'd9, 5'd8, 5'd0, 1, 0);
      tick();
      instr(CtrlAdd, 5'd8, 5'd9, 5'd10, 1, 1);
      in_flush = 1;
      #1;
      check("fl_stall", 32'(o_stall), 32'd0);
      tick();
      check("fl_valid", 32'(o_valid), 32'd0);
      check("fl_cnt", 32'(o_cnt), 32'd1);

      // Hold beats hazard for three cycles, then the hazard takes effect.
      instr(CtrlLw, 5'd9, 5'd8, 5'd0, 1, 0);
      tick();
      instr(CtrlAdd, 5'd8, 5'd9, 5'd10, 1, 1);
      in_hold = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_valid", 32'(o_valid), 32'd1);
         check("hold_wr", 32'(o_wr), 32'd8);
         check("hold_ctrl", 32'(o_ctrl), 32'(CtrlLw));
      end
      in_hold = 0;
      #1;
      check("hold_release_stall", 32'(o_stall), 32'd1);
      tick();
      check("hold_release_cnt", 32'(o_cnt), 32'd2);

      // jal writes $31 regardless of rt/rd.
      instr(CtrlJal, 5'd0, 5'd5, 5'd6, 0, 0);
      tick();
      check("jal_wr", 32'(o_wr), 32'd31);

      // Saturation: preload the counter just below the limit.
      idle();
      m_cnt = 32'hFFFE;
      force dut.bubble_cnt_q = 16'hFFFE;
      tick();
      release dut.bubble_cnt_q;
      for (int i = 0; i < 2; i++) begin
         instr(CtrlLw, 5'd9, 5'd8, 5'd0, 1, 0);
         tick();
         instr(CtrlAdd, 5'd8, 5'd9, 5'd10, 1, 1);
         tick();
         check("sat_cnt", 32'(o_cnt), 32'hFFFF);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         rand_inputs();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/p_id_ex.md
# p_id_ex

ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS pipeline. Captures the two operand words returned combinationally by the register file during decode, together with decoded control, immediate and register addresses, and presents them to the EX stage one cycle later. Detects a load in EX whose destination is a source of the instruction in ID, requests an upstream stall and inserts a bubble. Also handles branch flush, external hold and a saturating bubble counter.

## Interface
Parameters:
- none; all widths are fixed by the MIPS32 datapath.

Ports:
- i_sys_clock  in  1  system clock; state updates on posedge.
- i_sys_reset  in  1  synchronous, active-high reset, sampled on posedge.
- i_p_id_ex_valid  in  1  IF/ID holds a real instruction.
- i_p_id_ex_pc_plus4  in  32  PC+4 of the ID instruction.
- i_p_id_ex_rs_addr / i_p_id_ex_rt_addr / i_p_id_ex_rd_addr  in  5 each  instruction register fields.
- i_p_id_ex_uses_rs / i_p_id_ex_uses_rt  in  1 each  instruction actually reads rs / rt.
- i_p_id_ex_rs_data / i_p_id_ex_rt_data  in  32 each  register-file read data 1 / 2.
- i_p_id_ex_imm  in  32  sign- or zero-extended immediate.
- i_p_id_ex_ctrl  in  10  [0] regwr, [1] memrd, [2] memwr, [3] memtoreg, [4] alusrc, [5] regdst, [6] link, [9:7] aluop.
- i_p_id_ex_flush  in  1  branch/jump resolved taken in EX; kill ID instruction.
- i_p_id_ex_hold  in  1  global pipeline freeze (memory wait).
- o_p_id_ex_valid  out  1  EX-stage instruction is real.
- o_p_id_ex_pc_plus4, o_p_id_ex_rs_data, o_p_id_ex_rt_data, o_p_id_ex_imm  out  32 each  registered copies.
- o_p_id_ex_rs_addr / o_p_id_ex_rt_addr  out  5 each  for the EX forwarding unit.
- o_p_id_ex_wr_addr  out  5  resolved destination register.
- o_p_id_ex_ctrl  out  10  registered control, same bit map.
- o_p_id_ex_stall  out  1  load-use stall request to PC and IF/ID (combinational).
- o_p_id_ex_bubble_cnt  out  16  number of load-use bubbles inserted, saturating.

## Operation
- Destination resolution at capture: link=1 -> 31; else regdst=1 -> rd_addr; else rt_addr.
- Hazard (combinational): o_valid & o_ctrl[1] & o_wr_addr!=0 & i_valid & ((i_uses_rs & i_rs_addr==o_wr_addr) | (i_uses_rt & i_rt_addr==o_wr_addr)).
- o_p_id_ex_stall = hazard & ~i_flush & ~i_hold.
- Next-state priority on each posedge:
  1. reset: all outputs and counter to 0.
  2. flush: load bubble.
  3. hold: keep all contents unchanged.
  4. hazard: load bubble; bubble_cnt += 1 unless already 0xFFFF.
  5. otherwise: capture all inputs; o_valid = i_valid; if i_valid=0 capture as bubble.
- Bubble: valid=0 and every other output field 0 (ctrl all zero, so no regwr/memrd/memwr in later stages).
- Register file writes on negedge, so WB data written in cycle N is visible on rs/rt_data before the posedge of cycle N; no WB-to-ID bypass here.
- Register 0 never triggers a hazard.

## Timing
- Latency: 1 cycle, input at posedge N appears on outputs after posedge N.
- Reset: every output 0, including stall (o_valid=0 forces hazard=0).
- Load-use: stall high for exactly one cycle per load-use pair; upstream holds IF/ID and PC that cycle; next cycle the load has moved on, bubble is in ID/EX, hazard clears and the dependent instruction is captured.
- Flush and hazard together: flush wins, stall=0, counter unchanged.
- Hold and hazard together: stall=0, contents held, counter unchanged; hazard re-evaluated once hold drops.
- Reset asserted mid-stall: next cycle all zero, stall 0.

## Test plan
- Reset: assert reset 2 cycles with nonzero inputs -> all outputs 0, bubble_cnt 0.
- Pass-through: valid add rs=8 rt=9 rd=10, regdst=1, rs_data=0x11, rt_data=0x22 -> next cycle valid=1, wr_addr=10, data 0x11/0x22, ctrl equal.
- Load-use: lw to $t0 (memrd=1, regdst=0, rt=8) then add using rs=8 -> stall=1 one cycle, next output bubble, bubble_cnt=1, add captured the following cycle.
- No-hazard cases: lw to $0 then add rs=0; lw $t0 then instr with uses_rs=0 and rs=8 -> stall never asserted.
- Flush/hold priority: hazard with flush=1 -> stall=0, bubble loaded, count unchanged; hold=1 for 3 cycles -> outputs frozen, stall 0.
- Link and saturation: jal (link=1) -> wr_addr=31; preload 65535 bubbles -> counter stays 0xFFFF on next hazard.
